// File: rtl/fc_vec_stride_buf.sv
// rtl/fc_vec_stride_buf.sv - ping-pong serial-to-parallel buffer with strided lanes; macro RELU_EN enables write-side clamp
module fc_vec_stride_buf #(
  parameter int DATA_W = 32,
  parameter int LANES  = 128,
  parameter int PHASES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [15:0]             frame_cnt
);

  localparam int DEPTH = LANES * PHASES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = (PHASES > 1) ? $clog2(PHASES) : 1;

  // Two banks of one frame each; contents are never reset.
  logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          rd_bank;
  logic [PW-1:0] rd_phase;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [DATA_W-1:0] wdata;

  logic in_acc;
  logic out_acc;
  logic wr_last;
  logic rd_last;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign wr_last   = (wr_cnt == AW'(DEPTH - 1));
  assign rd_last   = (rd_phase == PW'(PHASES - 1));
  assign out_last  = out_valid && rd_last;

  // Word value actually stored: clamped to zero when negative in the RELU build.
  always_comb begin
    wdata = in_data;
`ifdef RELU_EN
    if (in_data[DATA_W-1]) begin
      wdata = '0;
    end
`else
    wdata = in_data;
`endif
  end

  // Bank occupancy: the filling bank and the draining bank are always different,
  // so a same-cycle set and clear never collide.
  always_comb begin
    full_nxt = full;
    if (in_acc && wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (out_acc && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  // Pointers, flags and frame counter; clr flushes everything and wins over handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_phase  <= '0;
      full      <= 2'b00;
      frame_cnt <= 16'd0;
    end else if (clr) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_phase  <= '0;
      full      <= 2'b00;
      frame_cnt <= 16'd0;
    end else begin
      full <= full_nxt;
      if (in_acc) begin
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
      if (out_acc) begin
        if (rd_last) begin
          rd_phase  <= '0;
          rd_bank   <= !rd_bank;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          rd_phase <= rd_phase + PW'(1);
        end
      end
    end
  end

  // Storage write on every accepted word; a flush cycle writes nothing.
  always_ff @(posedge clk) begin
    if (in_acc && !clr) begin
      mem[wr_bank][wr_cnt] <= wdata;
    end
  end

  // Strided beat gather: lane k of phase p is word PHASES*k + p of the draining bank.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int k = 0; k < LANES; k++) begin
        out_data[k*DATA_W +: DATA_W] = mem[rd_bank][AW'(PHASES * k) + AW'(rd_phase)];
      end
    end
  end

endmodule

// File: tb/tb_fc_vec_stride_buf.sv
// tb/tb_fc_vec_stride_buf.sv - self-checking bench for fc_vec_stride_buf (small and default-parameter instances)
module tb_fc_vec_stride_buf;

  localparam int DW = 32;
  localparam int NL = 4;
  localparam int NP = 4;
  localparam int FW = NL * NP;
  localparam int DL = 128;

  logic clk;
  logic rst_n;
  logic clr;

  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [NL*DW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [15:0]      frame_cnt;

  logic [DW-1:0]    d_in_data;
  logic             d_in_valid;
  logic             d_in_ready;
  logic [DL*DW-1:0] d_out_data;
  logic             d_out_valid;
  logic             d_out_ready;
  logic             d_out_last;
  logic [15:0]      d_frame_cnt;

  fc_vec_stride_buf #(.DATA_W(DW), .LANES(NL), .PHASES(NP)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_cnt(frame_cnt)
  );

  fc_vec_stride_buf dut_dflt (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_last(d_out_last), .frame_cnt(d_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: partial frame words, pending beats with their last flags, drained frames.
  logic [DW-1:0]    part[$];
  logic [NL*DW-1:0] beatq[$];
  bit               lastq[$];
  int               mfc;
  bit               last_acc;

  task automatic chk(input string tag, input logic [NL*DW-1:0] obs, input logic [NL*DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] w);
`ifdef RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic model_clear();
    part.delete();
    beatq.delete();
    lastq.delete();
    mfc = 0;
  endtask

  task automatic model_update(input bit ai, input bit ao, input logic [DW-1:0] w);
    logic [NL*DW-1:0] b;
    if (ao && beatq.size() > 0) begin
      void'(beatq.pop_front());
      if (lastq.pop_front()) mfc = (mfc + 1) % 65536;
    end
    if (ai) begin
      part.push_back(stored(w));
      if (part.size() == FW) begin
        for (int p = 0; p < NP; p++) begin
          b = '0;
          for (int k = 0; k < NL; k++) b[k*DW +: DW] = part[NP*k + p];
          beatq.push_back(b);
          lastq.push_back(p == NP - 1);
        end
        part.delete();
      end
    end
  endtask

  task automatic model_check();
    int pend;
    pend = (beatq.size() + NP - 1) / NP;
    chk("in_ready", in_ready, pend < 2);
    chk("out_valid", out_valid, beatq.size() != 0);
    chk("out_data", out_data, (beatq.size() != 0) ? beatq[0] : '0);
    chk("out_last", out_last, (lastq.size() != 0) ? lastq[0] : 1'b0);
    chk("frame_cnt", frame_cnt, mfc);
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy);
    bit ai;
    bit ao;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    model_check();
    ai = in_valid && in_ready;
    ao = out_valid && out_ready;
    @(posedge clk);
    if (clr) model_clear();
    else model_update(ai, ao, id);
    last_acc = ai;
    #1;
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic send(input logic [DW-1:0] w, input int mode);
    for (int n = 0; n < 300; n++) begin
      cyc(1'b1, w, pick_ready(mode));
      if (last_acc) return;
    end
    chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input int mode);
    for (int n = 0; n < 300; n++) begin
      if (beatq.size() == 0) break;
      cyc(1'b0, '0, pick_ready(mode));
    end
    chk("drain_done", beatq.size() == 0, 1'b1);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_default();
    int wi;
    int nb;
    int stalls;
    int mism;
    int f;
    int p;
    bit ai;
    wi = 0;
    nb = 0;
    stalls = 0;
    d_out_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (wi == 1024 && nb == 8) break;
      d_in_valid = (wi < 1024);
      d_in_data  = DW'(wi);
      @(negedge clk);
      if (d_in_valid && !d_in_ready) stalls++;
      if (d_out_valid) begin
        f = nb / 4;
        p = nb % 4;
        mism = 0;
        for (int k = 0; k < DL; k++)
          if (d_out_data[k*DW +: DW] !== DW'(f * 512 + 4 * k + p)) mism++;
        chk("dflt_beat", mism, 0);
        chk("dflt_last", d_out_last, p == 3);
        nb++;
      end
      ai = d_in_valid && d_in_ready;
      @(posedge clk);
      if (ai) wi++;
      #1;
    end
    d_in_valid = 1'b0;
    chk("dflt_words", wi, 1024);
    chk("dflt_beats", nb, 8);
    chk("dflt_stalls", stalls, 0);
    @(negedge clk);
    chk("dflt_frame_cnt", d_frame_cnt, 16'd2);
    chk("dflt_idle", d_out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    d_in_valid = 1'b0;
    d_in_data = '0;
    d_out_ready = 1'b0;
    model_clear();
    #1;
    do_reset();

    // Fill: 0..15 with the consumer always ready.
    for (int i = 0; i < FW; i++) send(DW'(i), 1);
    drain(1);
    chk("s1_frame_cnt", frame_cnt, 16'd1);

    // Ping-pong: two frames with no consumer, then a stall on the third frame's first word.
    for (int i = 0; i < 2 * FW; i++) send(DW'(100 + i), 0);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, DW'(132), 1'b0);
      chk("s2_stall", last_acc, 1'b0);
    end
    drain(1);
    chk("s2_frame_cnt", frame_cnt, 16'd3);

    // Backpressure with random data, random input gaps and random consumer readiness.
    for (int i = 0; i < 3 * FW; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, '0, pick_ready(2));
      send($urandom, 2);
    end
    drain(2);
    chk("s3_frame_cnt", frame_cnt, 16'd6);

    // Mid-frame reset drops the partial frame.
    for (int i = 0; i < 7; i++) send(DW'(500 + i), 1);
    do_reset();
    for (int i = 0; i < FW; i++) send(DW'(i), 1);
    drain(1);
    chk("s4_rst_frame_cnt", frame_cnt, 16'd1);

    // Same with a synchronous flush, issued while the consumer is also ready.
    for (int i = 0; i < 7; i++) send(DW'(600 + i), 1);
    clr = 1'b1;
    cyc(1'b1, DW'(999), 1'b1);
    clr = 1'b0;
    for (int i = 0; i < FW; i++) send(DW'(i), 1);
    drain(1);
    chk("s4_clr_frame_cnt", frame_cnt, 16'd1);

    // Flush with both banks full discards both.
    for (int i = 0; i < 2 * FW; i++) send(DW'(700 + i), 0);
    clr = 1'b1;
    cyc(1'b0, '0, 1'b1);
    clr = 1'b0;
    cyc(1'b0, '0, 1'b1);

    // Signed data: -5 / 7 alternating.
    for (int i = 0; i < FW; i++) send((i % 2 == 0) ? 32'hFFFF_FFFB : 32'd7, 1);
    drain(1);

    // Default parameters: two back-to-back 512-word frames.
    do_reset();
    run_default();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
